// File: rtl/pwm_ramp_ctrl_pkg.sv
// Shared definitions for PWM sequencers: data width, sequencer states and the
// target-clip / duty-step helpers.
package pwm_ramp_ctrl_pkg;

  localparam int unsigned PWM_W = 16;

  typedef enum logic [1:0] {StIdle, StArm, StRamp} state_e;

  // Duty may not exceed the period (100 % high).
  function automatic logic [PWM_W-1:0] clip_target(input logic [PWM_W-1:0] tgt,
                                                   input logic [PWM_W-1:0] per);
    return (tgt > per) ? per : tgt;
  endfunction

  // One ramp step toward tgt; the last partial step lands exactly on tgt.
  function automatic logic [PWM_W-1:0] next_duty(input logic [PWM_W-1:0] duty,
                                                 input logic [PWM_W-1:0] tgt,
                                                 input logic [PWM_W-1:0] step);
    logic [PWM_W:0] diff;
    logic [PWM_W-1:0] res;
    if (step == '0) begin
      res = tgt;
    end else if (tgt >= duty) begin
      diff = {1'b0, tgt} - {1'b0, duty};
      res  = (diff <= {1'b0, step}) ? tgt : duty + step;
    end else begin
      diff = {1'b0, duty} - {1'b0, tgt};
      res  = (diff <= {1'b0, step}) ? tgt : duty - step;
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_ramp_ctrl_frame_tracker.sv
// Mirror of the PWM generator frame counter; flags the last cycle of each frame.
module pwm_frame_tracker #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] period_i,
  output logic         frame_end_o
);

  logic [W-1:0] fcnt_q, fcnt_d;

  // Periods 0 and 1 both collapse to a one-cycle frame.
  assign frame_end_o = (period_i <= W'(1)) || (fcnt_q >= period_i - W'(1));

  always_comb begin
    fcnt_d = frame_end_o ? '0 : fcnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Ramp sequencer in front of a PWM generator: accepts one command and walks the
// duty toward its target, updating duty/period only at generator frame boundaries.
module pwm_ramp_ctrl
  import pwm_ramp_ctrl_pkg::*;
#(
  parameter logic [PWM_W-1:0] PERIOD_RST = 16'd1000,
  parameter int unsigned      IVL_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PWM_W-1:0] cfg_target,
  input  logic [PWM_W-1:0] cfg_period,
  input  logic [PWM_W-1:0] cfg_step,
  input  logic [IVL_W-1:0] cfg_interval,
  input  logic             abort,
  output logic [PWM_W-1:0] pwm_duty_o,
  output logic [PWM_W-1:0] pwm_period_o,
  output logic             frame_end_o,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [PWM_W-1:0] tgt_q, tgt_d;
  logic [PWM_W-1:0] per_q, per_d;
  logic [PWM_W-1:0] step_q, step_d;
  logic [IVL_W-1:0] ivl_q, ivl_d;
  logic [IVL_W-1:0] ivl_cnt_q, ivl_cnt_d;
  logic [PWM_W-1:0] duty_q, duty_d;
  logic [PWM_W-1:0] period_q, period_d;
  logic             done_q, done_d;
  logic [PWM_W-1:0] step_val;
  logic             frame_end;

  pwm_frame_tracker #(
    .W (PWM_W)
  ) u_frame_tracker (
    .clk         (clk),
    .rst_n       (rst_n),
    .period_i    (period_q),
    .frame_end_o (frame_end)
  );

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    per_d     = per_q;
    step_d    = step_q;
    ivl_d     = ivl_q;
    ivl_cnt_d = ivl_cnt_q;
    duty_d    = duty_q;
    period_d  = period_q;
    done_d    = 1'b0;
    step_val  = next_duty(duty_q, tgt_q, step_q);

    // Abort outranks both a pending handshake and a frame boundary.
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cfg_valid) begin
            tgt_d   = clip_target(cfg_target, cfg_period);
            per_d   = cfg_period;
            step_d  = cfg_step;
            ivl_d   = cfg_interval;
            state_d = StArm;
          end
        end
        StArm: begin
          if (frame_end) begin
            period_d  = per_q;
            ivl_cnt_d = '0;
            state_d   = StRamp;
          end
        end
        StRamp: begin
          if (frame_end) begin
            if (ivl_cnt_q == ivl_q) begin
              ivl_cnt_d = '0;
              duty_d    = step_val;
              if (step_val == tgt_q) begin
                done_d  = 1'b1;
                state_d = StIdle;
              end
            end else begin
              ivl_cnt_d = ivl_cnt_q + IVL_W'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      tgt_q     <= '0;
      per_q     <= '0;
      step_q    <= '0;
      ivl_q     <= '0;
      ivl_cnt_q <= '0;
      duty_q    <= '0;
      period_q  <= PERIOD_RST;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      per_q     <= per_d;
      step_q    <= step_d;
      ivl_q     <= ivl_d;
      ivl_cnt_q <= ivl_cnt_d;
      duty_q    <= duty_d;
      period_q  <= period_d;
      done_q    <= done_d;
    end
  end

  assign cfg_ready    = (state_q == StIdle);
  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign pwm_duty_o   = duty_q;
  assign pwm_period_o = period_q;
  assign frame_end_o  = frame_end;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: directed vector table, hand-written corner sequences and
// randomized commands, all checked every cycle against a frame-scheduling model.
module tb_pwm_ramp_ctrl;

  localparam int IVL_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [15:0]       cfg_target = '0;
  logic [15:0]       cfg_period = '0;
  logic [15:0]       cfg_step = '0;
  logic [IVL_W-1:0]  cfg_interval = '0;
  logic              abort = 1'b0;
  logic [15:0]       pwm_duty_o;
  logic [15:0]       pwm_period_o;
  logic              frame_end_o;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  pwm_ramp_ctrl #(
    .PERIOD_RST (16'd1000),
    .IVL_W      (IVL_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_target   (cfg_target),
    .cfg_period   (cfg_period),
    .cfg_step     (cfg_step),
    .cfg_interval (cfg_interval),
    .abort        (abort),
    .pwm_duty_o   (pwm_duty_o),
    .pwm_period_o (pwm_period_o),
    .frame_end_o  (frame_end_o),
    .busy         (busy),
    .done         (done)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 waiting for first frame end, 2 ramping.
  int m_phase, m_duty, m_period, m_tgt, m_per, m_step, m_ivl, m_left;
  int m_cyc, m_next_fe;
  bit m_done;
  int m_q[$];

  function automatic int max1(input int p);
    return (p < 1) ? 1 : p;
  endfunction

  task automatic model_reset();
    m_phase   = 0;
    m_duty    = 0;
    m_period  = 1000;
    m_done    = 0;
    m_cyc     = 0;
    m_next_fe = 999;
    m_q.delete();
  endtask

  // Precompute the whole list of duty values this ramp will visit.
  task automatic plan_ramp();
    int d;
    m_q.delete();
    d = m_duty;
    do begin
      if (m_step == 0) d = m_tgt;
      else if (d < m_tgt) d = (d + m_step > m_tgt) ? m_tgt : d + m_step;
      else d = (d - m_step < m_tgt) ? m_tgt : d - m_step;
      m_q.push_back(d);
    end while (d != m_tgt);
  endtask

  task automatic check_outputs();
    chk("duty", pwm_duty_o, m_duty);
    chk("period", pwm_period_o, m_period);
    chk("frame_end", frame_end_o, m_cyc == m_next_fe);
    chk("busy", busy, m_phase != 0);
    chk("ready", cfg_ready, m_phase == 0);
    chk("done", done, m_done);
  endtask

  task automatic tick();
    bit fe;
    fe = (m_cyc == m_next_fe);
    m_done = 0;
    if (abort) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (cfg_valid) begin
          m_tgt   = (int'(cfg_target) > int'(cfg_period)) ? int'(cfg_period) : int'(cfg_target);
          m_per   = cfg_period;
          m_step  = cfg_step;
          m_ivl   = cfg_interval;
          m_phase = 1;
        end
        1: if (fe) begin
          m_period = m_per;
          m_left   = m_ivl;
          plan_ramp();
          m_phase  = 2;
        end
        default: if (fe) begin
          if (m_left == 0) begin
            m_duty = m_q.pop_front();
            m_left = m_ivl;
            if (m_q.size() == 0) begin
              m_done  = 1;
              m_phase = 0;
            end
          end else begin
            m_left--;
          end
        end
      endcase
    end
    if (fe) m_next_fe = m_cyc + max1(m_period);
    @(posedge clk);
    #1;
    m_cyc++;
    check_outputs();
  endtask

  task automatic cmd(input int tgt, input int per, input int step, input int ivl);
    cfg_target   = 16'(tgt);
    cfg_period   = 16'(per);
    cfg_step     = 16'(step);
    cfg_interval = IVL_W'(ivl);
    cfg_valid    = 1'b1;
    tick();
    cfg_valid    = 1'b0;
  endtask

  typedef struct {
    int tgt;
    int per;
    int step;
    int ivl;
    int n;
    int seq[4];
  } vec_t;

  vec_t tbl[4];

  initial begin
    int fe_cnt, ndone, k, prev;
    int obs[$];
    int obs_cyc[$];

    tbl[0] = '{100, 200, 30, 0, 4, '{30, 60, 90, 100}};
    tbl[1] = '{10, 200, 40, 2, 3, '{60, 20, 10, 0}};
    tbl[2] = '{500, 200, 0, 0, 1, '{200, 0, 0, 0}};
    tbl[3] = '{200, 200, 5, 1, 0, '{0, 0, 0, 0}};

    // Reset values, then free-running frames at the reset period.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_duty", pwm_duty_o, 0);
    chk("rst_period", pwm_period_o, 1000);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_outputs();
    fe_cnt = 0;
    repeat (2100) begin
      tick();
      if (frame_end_o) fe_cnt++;
    end
    chk("rst_frame_count", fe_cnt, 2);

    // Directed table: up-ramp, down-ramp with interval, clip/jump, target == duty.
    foreach (tbl[i]) begin
      obs.delete();
      obs_cyc.delete();
      ndone = 0;
      cmd(tbl[i].tgt, tbl[i].per, tbl[i].step, tbl[i].ivl);
      prev = pwm_duty_o;
      k = 0;
      while (ndone == 0 && k < 5000) begin
        tick();
        k++;
        if (done) ndone++;
        if (pwm_duty_o != 16'(prev)) begin
          obs.push_back(pwm_duty_o);
          obs_cyc.push_back(m_cyc);
          prev = pwm_duty_o;
        end
      end
      chk("tbl_timeout", k < 5000, 1);
      repeat (5) begin
        tick();
        if (done) ndone++;
      end
      chk("tbl_done_once", ndone, 1);
      chk("tbl_nsteps", obs.size(), tbl[i].n);
      for (int j = 0; j < tbl[i].n && j < obs.size(); j++) chk("tbl_seq", obs[j], tbl[i].seq[j]);
      for (int j = 1; j < obs_cyc.size(); j++)
        chk("tbl_spacing", obs_cyc[j] - obs_cyc[j-1], (tbl[i].ivl + 1) * tbl[i].per);
      if (i == 2) chk("clip_full_high", pwm_duty_o >= pwm_period_o, 1);
    end

    // Abort mid-ramp at duty 60, then an immediate new command.
    cmd(0, 200, 70, 0);
    k = 0;
    while (pwm_duty_o != 16'd60 && k < 3000) begin
      tick();
      k++;
    end
    chk("abort_reach60", pwm_duty_o, 60);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_duty", pwm_duty_o, 60);
    chk("abort_nodone", done, 0);
    cmd(60, 200, 5, 0);
    chk("abort_new_cmd", busy, 1);
    k = 0;
    while (m_phase != 0 && k < 3000) begin
      tick();
      k++;
    end
    chk("abort_next_done", k < 3000, 1);

    // cfg_valid while busy is ignored; async reset mid-ramp.
    cmd(180, 200, 10, 0);
    k = 0;
    while (m_phase != 2 && k < 3000) begin
      tick();
      k++;
    end
    cfg_target = 16'd5;
    cfg_valid  = 1'b1;
    repeat (10) begin
      tick();
      chk("busy_ready_low", cfg_ready, 0);
    end
    cfg_valid = 1'b0;
    k = 0;
    while (pwm_duty_o < 16'd100 && k < 3000) begin
      tick();
      k++;
    end
    chk("mid_ramp_reached", pwm_duty_o >= 16'd100, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_duty", pwm_duty_o, 0);
    chk("async_rst_period", pwm_period_o, 1000);
    chk("async_rst_busy", busy, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_outputs();
    repeat (1500) tick();
    chk("no_resume_duty", pwm_duty_o, 0);

    // Randomized commands with sporadic aborts and ignored mid-ramp commands.
    repeat (25) begin
      if ($urandom_range(0, 4) == 0) begin
        abort     = 1'b1;
        cfg_valid = 1'b1;
        tick();
        abort     = 1'b0;
        cfg_valid = 1'b0;
      end
      cmd($urandom_range(0, 40), $urandom_range(0, 30), $urandom_range(0, 12),
          $urandom_range(0, 3));
      k = 0;
      while (m_phase != 0 && k < 10000) begin
        abort        = ($urandom_range(0, 299) == 0);
        cfg_valid    = ($urandom_range(0, 9) == 0);
        cfg_target   = 16'($urandom_range(0, 40));
        cfg_period   = 16'($urandom_range(0, 30));
        cfg_step     = 16'($urandom_range(0, 12));
        cfg_interval = IVL_W'($urandom_range(0, 3));
        tick();
        k++;
      end
      abort     = 1'b0;
      cfg_valid = 1'b0;
      chk("rand_timeout", k < 10000, 1);
      repeat ($urandom_range(0, 20)) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
